// File: rtl/plru_multiset.sv
// Multi-set binary-tree pseudo-LRU replacement engine with invalid-first fill and per-way invalidation.
// Optional way locking is enabled by defining PLRU_WAY_LOCK_EN (adds lock_mask / victim_none).
module plru_multiset #(
    parameter int WAYS = 16,
    parameter int SETS = 8,
    localparam int WAY_W = $clog2(WAYS),
    localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             access_valid,
    input  logic [SET_W-1:0] access_set,
    input  logic             access_hit,
    input  logic [WAY_W-1:0] access_hit_way,
    input  logic             inval_valid,
    input  logic [SET_W-1:0] inval_set,
    input  logic [WAY_W-1:0] inval_way,
    output logic             inval_ready,
    output logic             victim_valid,
    output logic [SET_W-1:0] victim_set,
    output logic [WAY_W-1:0] victim_way,
    output logic             victim_evict
`ifdef PLRU_WAY_LOCK_EN
    ,
    input  logic [WAYS-1:0]  lock_mask,
    output logic             victim_none
`endif
);

    if (WAYS < 2 || (WAYS & (WAYS - 1)) != 0) begin : g_bad_ways
        $error("plru_multiset: WAYS must be a power of two >= 2");
    end
    if (SETS < 1) begin : g_bad_sets
        $error("plru_multiset: SETS must be >= 1");
    end

    localparam bit ALL_SETS_ADDRESSABLE = (SETS == (1 << SET_W));

    // Heap-ordered tree bits per set: bit i is node i, 1 = next victim lies to the right.
    logic [WAYS-2:0] tree_q  [SETS];
    logic [WAYS-1:0] valid_q [SETS];

    logic [WAYS-1:0]  lock;
    logic             all_locked;
    logic             acc_in_range;
    logic             inval_in_range;
    logic             inval_fire;
    logic             miss;
    logic [WAYS-2:0]  acc_tree;
    logic [WAYS-1:0]  acc_valid_row;
    logic [WAYS-1:0]  free_ways;
    logic [WAYS-2:0]  tree_next;
    logic [WAYS-1:0]  valid_next;
    logic [WAY_W-1:0] victim_d;
    logic             evict_d;
    logic             update_d;

`ifdef PLRU_WAY_LOCK_EN
    assign lock = lock_mask;
`else
    assign lock = '0;
`endif
    assign all_locked = &lock;

    // Heap child index; the final step of a walk may overflow, but that value is never used.
    function automatic logic [WAY_W-1:0] next_node(input logic [WAY_W-1:0] n, input logic b);
        return WAY_W'(2 * int'(n) + 1 + int'(b));
    endfunction

    // Point every node on way w's root-to-leaf path away from w.
    function automatic logic [WAYS-2:0] touch(input logic [WAYS-2:0] t, input logic [WAY_W-1:0] w);
        logic [WAYS-2:0]  r;
        logic [WAY_W-1:0] node;
        logic             b;
        // NOTE: function locals are combinational temporaries, so blocking assignments are correct here.
        r    = t;
        node = '0;
        for (int d = 0; d < WAY_W; d++) begin
            b       = w[WAY_W-1-d];
            r[node] = ~b;
            node    = next_node(node, b);
        end
        return r;
    endfunction

    // True when some unlocked way shares the top depth+1 index bits with cand.
    function automatic logic subtree_free(input logic [WAYS-1:0] lk, input logic [WAY_W-1:0] cand,
                                          input int depth);
        logic f;
        int   sh;
        f  = 1'b0;
        sh = WAY_W - 1 - depth;
        for (int j = 0; j < WAYS; j++) begin
            if (!lk[j] && ((j >> sh) == (int'(cand) >> sh))) f = 1'b1;
        end
        return f;
    endfunction

    function automatic logic [WAY_W-1:0] tree_walk(input logic [WAYS-2:0] t, input logic [WAYS-1:0] lk);
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] way;
        logic             dir;
        node = '0;
        way  = '0;
        for (int d = 0; d < WAY_W; d++) begin
            dir              = t[node];
            way[WAY_W-1-d]   = dir;
            if (!subtree_free(lk, way, d)) begin
                dir            = ~dir;
                way[WAY_W-1-d] = dir;
            end
            node = next_node(node, dir);
        end
        return way;
    endfunction

    function automatic logic [WAY_W-1:0] lowest_set(input logic [WAYS-1:0] v);
        logic [WAY_W-1:0] r;
        r = '0;
        for (int j = WAYS - 1; j >= 0; j--) begin
            if (v[j]) r = WAY_W'(j);
        end
        return r;
    endfunction

    assign acc_in_range   = ALL_SETS_ADDRESSABLE || (int'(access_set) < SETS);
    assign inval_in_range = ALL_SETS_ADDRESSABLE || (int'(inval_set) < SETS);
    assign inval_ready    = rst || !(access_valid && (access_set == inval_set));
    assign inval_fire     = inval_valid && inval_ready && inval_in_range;
    assign miss           = access_valid && !access_hit && acc_in_range;

    assign acc_tree      = acc_in_range ? tree_q[access_set]  : '0;
    assign acc_valid_row = acc_in_range ? valid_q[access_set] : '0;
    assign free_ways     = ~acc_valid_row & ~lock;

    always_comb begin
        tree_next  = acc_tree;
        valid_next = acc_valid_row;
        victim_d   = '0;
        evict_d    = 1'b0;
        update_d   = 1'b0;
        if (access_valid && acc_in_range) begin
            if (access_hit) begin
                update_d  = 1'b1;
                tree_next = touch(acc_tree, access_hit_way);
            end else if (!all_locked) begin
                update_d = 1'b1;
                if (|free_ways) begin
                    victim_d = lowest_set(free_ways);
                end else begin
                    victim_d = tree_walk(acc_tree, lock);
                    evict_d  = 1'b1;
                end
                valid_next[victim_d] = 1'b1;
                tree_next            = touch(acc_tree, victim_d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: tree and valid state are flops, not RAM, because reset must empty every set at once.
            for (int s = 0; s < SETS; s++) begin
                tree_q[s]  <= '0;
                valid_q[s] <= '0;
            end
            victim_valid <= 1'b0;
            victim_set   <= '0;
            victim_way   <= '0;
            victim_evict <= 1'b0;
`ifdef PLRU_WAY_LOCK_EN
            victim_none  <= 1'b0;
`endif
        end else begin
            victim_valid <= miss;
            if (miss) begin
                victim_set   <= access_set;
                victim_way   <= victim_d;
                victim_evict <= evict_d;
            end
`ifdef PLRU_WAY_LOCK_EN
            victim_none <= miss && all_locked;
`endif
            // inval_ready guarantees the invalidated set differs from any updated access set.
            if (inval_fire) valid_q[inval_set][inval_way] <= 1'b0;
            if (update_d) begin
                tree_q[access_set]  <= tree_next;
                valid_q[access_set] <= valid_next;
            end
        end
    end

endmodule

// File: doc/plru_multiset.md
Name: plru_multiset

Overview:
- Parametrised multi-set pseudo-LRU replacement engine for the IFU instruction cache.
- Keeps one binary PLRU tree and one valid vector per set, for any power-of-two way count.
- On a miss it returns a registered victim way. It fills invalid ways first (lowest index), then uses the tree. It also supports per-way invalidation, e.g. for fence.i or a snoop.

Parameters:
- WAYS, 16, associativity; power of two, >= 2
- SETS, 8, number of sets; >= 1
- WAY_W, $clog2(WAYS), way index width (derived, not overridable)
- SET_W, (SETS>1 ? $clog2(SETS) : 1), set index width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- access_valid  in  1  lookup result for one access this cycle
- access_set  in  SET_W  set of the access
- access_hit  in  1  1 = hit, 0 = miss
- access_hit_way  in  WAY_W  way that hit (ignored on miss)
- inval_valid  in  1  invalidate request
- inval_set  in  SET_W  set to invalidate
- inval_way  in  WAY_W  way to invalidate
- inval_ready  out  1  invalidate accepted this cycle
- victim_valid  out  1  registered victim response for the previous cycle's miss
- victim_set  out  SET_W  set of the victim
- victim_way  out  WAY_W  way chosen for fill/eviction
- victim_evict  out  1  1 = victim way held valid data (real eviction), 0 = fill of an invalid way

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset clears all tree bits, all valid bits, victim_valid, victim_set, victim_way and victim_evict to 0. Reset wins over any same-cycle request.
- Reset mid-operation: state is cleared and any pending victim response is dropped.
- Tree layout: heap order, nodes 0..WAYS-2; children of node i are 2i+1 and 2i+2. Leaves map to ways 0..WAYS-1, left to right.
- Tree bit meaning: 0 = next victim lies in the left subtree; 1 = it lies in the right subtree.
- Touch(set, w): every node on w's path is written to point away from w. All other nodes are unchanged.
- Hit (access_valid & access_hit): Touch(access_set, access_hit_way). No response.
  - A hit on a way whose valid bit is 0 still touches the tree; the valid bit stays unchanged.
- Miss (access_valid & !access_hit):
  - If the set has any invalid way: victim = lowest-index invalid way, victim_evict = 0.
  - Otherwise: victim = leaf reached by walking from the root following the tree bits, victim_evict = 1.
  - In the same cycle the victim's valid bit is set to 1 and the set is touched with the victim.
  - The next cycle drives victim_valid = 1 with victim_set/victim_way/victim_evict. Latency is exactly 1 cycle.
  - victim_valid is a single-cycle pulse; back-to-back misses give back-to-back pulses.
- Invalidate:
  - inval_ready = !(access_valid && access_set == inval_set); combinational; 1 during reset.
  - When inval_valid & inval_ready: the valid bit of (inval_set, inval_way) is cleared. The tree is untouched.
  - If not ready, the requester holds the request.
- Access and invalidate to different sets in the same cycle are both applied.
- Every access evaluates the state registered at the start of the cycle; updates are visible on the next cycle.
- Indices >= SETS are out of range: those requests are ignored. A miss with an out-of-range set produces no response.

Optional Feature:
- Macro: PLRU_WAY_LOCK_EN.
- When defined:
  - Adds input lock_mask [WAYS-1:0] and output victim_none (1 bit, reset 0).
  - Locked ways are never chosen as the victim. The invalid-first search skips locked ways.
  - During the tree walk, if a node's indicated subtree is entirely locked, the other subtree is taken.
  - If every way is locked: victim_valid = 1 and victim_none = 1 next cycle, victim_way = 0, with no valid or tree update.
  - Hits on locked ways touch the tree normally.
- When undefined: neither port exists and behaviour is exactly the base behaviour above.

Test Plan:
- WAYS=4, SETS=8. Reset, then 4 misses to set 3 on consecutive cycles -> victim_way 0,1,2,3 on the 4 following cycles, all with victim_evict = 0, victim_set = 3.
- Continue: 5th miss to set 3 -> victim_way 0, evict = 1. Then hit way 0 and miss -> victim_way 2, evict = 1.
- Fill set 3 fully, invalidate way 2 of set 3, then miss set 3 -> victim_way 2, evict = 0. Meanwhile set 5 is still empty: a miss there -> victim_way 0, evict = 0.
- Same cycle: miss on set 1 plus invalidate on set 1 -> inval_ready = 0. Invalidate is accepted on the next cycle when access_valid = 0 and clears the filled way.
- Assert rst on the cycle after a miss -> victim_valid = 0 that cycle. All sets are empty afterwards: the next miss returns way 0 with evict = 0.
- PLRU_WAY_LOCK_EN, WAYS=4, set full, lock_mask = 4'b0001, tree pointing to way 0 -> victim_way = 1. With lock_mask = 4'b1111 -> victim_none = 1.
